ssd_scanner: RTL and testbench

SSD_SCANNER -- requirements
Module: ssd_scanner

---
 rtl/ssd_scanner_if.sv | 21 ++
 rtl/ssd_scanner.sv | 111 +++++++++++
 tb/tb_ssd_scanner.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ssd_scanner_if.sv
// Display-side bundle of the seven-segment scanner: the value/load request from
// the producer and the registered scan outputs toward the digit drivers.
interface ssd_scanner_if;
    logic [15:0] value;
    logic        load;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame;
    logic        busy;

    modport master (
        output value, load,
        input  nibble, an, digit_idx, frame, busy
    );

    modport slave (
        input  value, load,
        output nibble, an, digit_idx, frame, busy
    );
endinterface

// File: rtl/ssd_scanner.sv
// Four-digit multiplexed hex display scanner with tear-free double buffering
// (new values take effect only at a frame boundary) and optional leading-zero blanking.
module ssd_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    ssd_scanner_if.slave  bus
);

    localparam int                CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       digit_idx_q, digit_idx_d;
    logic [15:0]      pending_q, pending_d;
    logic [15:0]      shown_q, shown_d;
    logic             busy_q, busy_d;
    logic             frame_q, frame_d;
    logic [3:0]       nibble_q, nibble_d;
    logic [3:0]       an_q, an_d;

    logic tick;
    logic wrap;

    function automatic logic [3:0] digit_of(input logic [15:0] v, input logic [1:0] idx);
        logic [3:0] d;
        case (idx)
            2'd0:    d = v[3:0];
            2'd1:    d = v[7:4];
            2'd2:    d = v[11:8];
            default: d = v[15:12];
        endcase
        return d;
    endfunction

    // Digit 0 always stays lit so a zero value still shows a single "0".
    function automatic logic leading_zero(input logic [15:0] v, input logic [1:0] idx);
        logic z;
        case (idx)
            2'd0:    z = 1'b0;
            2'd1:    z = (v[15:4] == 12'h000);
            2'd2:    z = (v[15:8] == 8'h00);
            default: z = (v[15:12] == 4'h0);
        endcase
        return z;
    endfunction

    always_comb begin
        tick        = (cnt_q == CNT_MAX);
        wrap        = tick && (digit_idx_q == 2'd3);
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        digit_idx_d = tick ? digit_idx_q + 2'd1 : digit_idx_q;

        shown_d   = shown_q;
        pending_d = pending_q;
        busy_d    = busy_q;
        if (wrap && busy_q) begin
            shown_d = pending_q;
            busy_d  = 1'b0;
        end
        // A load on the wrap tick lands after the swap: the older pending is shown,
        // the new value waits for the following frame.
        if (bus.load) begin
            pending_d = bus.value;
            busy_d    = 1'b1;
        end

        frame_d = wrap;

        // NOTE: nibble/an are derived from the next-state index and buffer so the
        // registered outputs line up with digit_idx in the same cycle.
        nibble_d = digit_of(shown_d, digit_idx_d);
        if (LZ_BLANK && leading_zero(shown_d, digit_idx_d))
            an_d = 4'b1111;
        else
            an_d = ~(4'b0001 << digit_idx_d);
    end

    // NOTE: sequential state uses non-blocking assignments only; the reset here is
    // synchronous, so it is sampled like any other input on the rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            digit_idx_q <= 2'd0;
            pending_q   <= 16'h0000;
            shown_q     <= 16'h0000;
            busy_q      <= 1'b0;
            frame_q     <= 1'b0;
            nibble_q    <= 4'h0;
            an_q        <= 4'b1110;
        end else begin
            cnt_q       <= cnt_d;
            digit_idx_q <= digit_idx_d;
            pending_q   <= pending_d;
            shown_q     <= shown_d;
            busy_q      <= busy_d;
            frame_q     <= frame_d;
            nibble_q    <= nibble_d;
            an_q        <= an_d;
        end
    end

    assign bus.nibble    = nibble_q;
    assign bus.an        = an_q;
    assign bus.digit_idx = digit_idx_q;
    assign bus.frame     = frame_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ssd_scanner.sv
// Directed bench for ssd_scanner at REFRESH_DIV=4: one instance with leading-zero
// blanking and one without, driven with identical stimulus.
module tb_ssd_scanner;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    ssd_scanner_if bus ();
    ssd_scanner_if bus_nolz ();

    assign bus_nolz.value = bus.value;
    assign bus_nolz.load  = bus.load;

    ssd_scanner #(.REFRESH_DIV(4), .LZ_BLANK(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ssd_scanner #(.REFRESH_DIV(4), .LZ_BLANK(1'b0)) dut_nolz (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nolz)
    );

    always #5 clk = ~clk;

    // an pattern with every digit lit, packed {digit3, digit2, digit1, digit0}
    logic [15:0] an_all_lit = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(input int budget);
        int n = 0;
        while (bus.frame !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        check("wait_frame", bus.frame, 1);
    endtask

    // Called on the frame-pulse cycle; walks one full 16-cycle frame.
    task automatic scan_frame(input string tag, input logic [15:0] val, input logic [15:0] an_lz);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("%s_d%0d_c%0d_frame", tag, d, c), bus.frame, (d == 0 && c == 0));
                check($sformatf("%s_d%0d_c%0d_idx", tag, d, c), bus.digit_idx, d);
                check($sformatf("%s_d%0d_c%0d_nib", tag, d, c), bus.nibble, val[4*d +: 4]);
                check($sformatf("%s_d%0d_c%0d_an", tag, d, c), bus.an, an_lz[4*d +: 4]);
                check($sformatf("%s_d%0d_c%0d_an_nolz", tag, d, c), bus_nolz.an, an_all_lit[4*d +: 4]);
                step(1);
            end
        end
    endtask

    initial begin
        int bad_nib;
        int first_frame;

        reset     = 1'b1;
        bus.load  = 1'b0;
        bus.value = 16'h0000;
        step(2);
        check("rst_idx", bus.digit_idx, 0);
        check("rst_an", bus.an, 4'b1110);
        check("rst_nib", bus.nibble, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_frame", bus.frame, 0);

        // Scan order after loading 1234
        reset     = 1'b0;
        bus.load  = 1'b1;
        bus.value = 16'h1234;
        step(1);
        bus.load = 1'b0;
        check("load_busy", bus.busy, 1);
        check("load_nib_old", bus.nibble, 0);
        wait_frame(40);
        check("apply_busy", bus.busy, 0);
        scan_frame("s1234", 16'h1234, an_all_lit);

        // Tear-free update: load ABCD while digit 1 is scanned
        step(4);
        bus.load  = 1'b1;
        bus.value = 16'hABCD;
        step(1);
        bus.load = 1'b0;
        check("tear_busy1", bus.busy, 1);
        check("tear_nib1", bus.nibble, 4'h3);
        step(3);
        check("tear_nib2", bus.nibble, 4'h2);
        check("tear_an2", bus.an, 4'b1011);
        step(4);
        check("tear_nib3", bus.nibble, 4'h1);
        check("tear_busy3", bus.busy, 1);
        step(4);
        check("tear_busy_clr", bus.busy, 0);
        scan_frame("sABCD", 16'hABCD, an_all_lit);

        // Leading-zero blanking
        bus.load  = 1'b1;
        bus.value = 16'h0050;
        step(1);
        bus.load = 1'b0;
        step(15);
        scan_frame("s0050", 16'h0050, {4'b1111, 4'b1111, 4'b1101, 4'b1110});
        bus.load  = 1'b1;
        bus.value = 16'h0000;
        step(1);
        bus.load = 1'b0;
        step(15);
        scan_frame("s0000", 16'h0000, {4'b1111, 4'b1111, 4'b1111, 4'b1110});

        // Last load wins within one frame
        bus.load  = 1'b1;
        bus.value = 16'h1111;
        step(1);
        bus.load = 1'b0;
        step(3);
        bus.load  = 1'b1;
        bus.value = 16'h2222;
        step(1);
        bus.load = 1'b0;
        step(11);
        scan_frame("s2222", 16'h2222, an_all_lit);

        // Load coinciding with the 3->0 tick
        bus.load  = 1'b1;
        bus.value = 16'h3333;
        step(1);
        bus.load = 1'b0;
        step(14);
        bus.load  = 1'b1;
        bus.value = 16'h4444;
        step(1);
        bus.load = 1'b0;
        check("coinc_frame", bus.frame, 1);
        check("coinc_busy", bus.busy, 1);
        check("coinc_nib", bus.nibble, 4'h3);
        scan_frame("s3333", 16'h3333, an_all_lit);
        check("coinc_busy_clr", bus.busy, 0);
        scan_frame("s4444", 16'h4444, an_all_lit);

        // Reset while busy, with a load on the reset cycle
        bus.load  = 1'b1;
        bus.value = 16'h9999;
        step(1);
        bus.load = 1'b0;
        step(3);
        check("pre_rst_busy", bus.busy, 1);
        reset     = 1'b1;
        bus.load  = 1'b1;
        bus.value = 16'h7777;
        step(1);
        reset    = 1'b0;
        bus.load = 1'b0;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_idx", bus.digit_idx, 0);
        check("mid_rst_an", bus.an, 4'b1110);
        check("mid_rst_nib", bus.nibble, 0);
        check("mid_rst_frame", bus.frame, 0);
        bad_nib     = 0;
        first_frame = 0;
        for (int i = 1; i <= 16; i++) begin
            step(1);
            if (bus.nibble == 4'h9 || bus.nibble == 4'h7 || bus.busy) bad_nib++;
            if (bus.frame && first_frame == 0) first_frame = i;
        end
        check("post_rst_stale", bad_nib, 0);
        check("post_rst_frame_at", first_frame, 16);
        scan_frame("s_after_rst", 16'h0000, {4'b1111, 4'b1111, 4'b1111, 4'b1110});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
